vga_draw_controller: RTL and testbench
======================================

Name: vga_draw_controller

Overview:
- Control/datapath block for the VGA plotting path.
- Latches a base X coordinate, then a base Y and colour, and sweeps a BOX_W x BOX_H filled box into the VGA adapter, one pixel per clock.
- Also supports a full-screen clear to black.
- Generalises the single-pixel load-x/load-y/plot/black FSM with parametrised screen, box size and colour depth, a busy/done handshake, and off-screen clipping.

Parameters:
- X_W, 8, width of X coordinate.
- Y_W, 7, width of Y coordinate.
- COLOUR_W, 3, colour width.
- SCREEN_W, 160, visible columns.
- SCREEN_H, 120, visible rows.
- BOX_W, 4, box width in pixels (>=1).
- BOX_H, 4, box height in pixels (>=1).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- ResetN  in  1  synchronous, active-low reset.
- data_in  in  X_W  coordinate bus; X on ld_x, Y in data_in[Y_W-1:0] on plot.
- colour_in  in  COLOUR_W  colour, sampled on plot.
- ld_x  in  1  load X base.
- plot  in  1  load Y/colour and start box draw.
- black  in  1  start full-screen clear.
- x_out  out  X_W  pixel X to adapter.
- y_out  out  Y_W  pixel Y to adapter.
- colour_out  out  COLOUR_W  pixel colour.
- writeEn  out  1  adapter write strobe.
- busy  out  1  high while drawing or clearing.
- done  out  1  one-cycle pulse at end of an operation.

Behaviour:
- One clock (clock). Reset is synchronous and active-low (ResetN); when ResetN=0 at a rising edge:
  - state=IDLE, x_base=0, y_base=0, colour reg=0.
  - All outputs 0.
- States: IDLE, XHELD, DRAW, CLEAR, DONE.
- Input priority in IDLE/XHELD: black > plot > ld_x.
  - ld_x: x_base<=data_in; go to XHELD.
  - plot: y_base<=data_in[Y_W-1:0], colour<=colour_in, dx=dy=0; go to DRAW. In IDLE, plot reuses the stored x_base.
  - black: dx=dy=0; go to CLEAR.
- In DRAW, CLEAR and DONE, ld_x/plot/black are ignored. busy=1 in DRAW and CLEAR, 0 otherwise.
- DRAW, one pixel per cycle in raster order (dx fastest):
  - Registered outputs: x_out=x_base+dx, y_out=y_base+dy, colour_out=colour.
  - First pixel appears the cycle after plot is sampled. Exactly BOX_W*BOX_H DRAW cycles.
- Clipping: the sum is computed at X_W+1 / Y_W+1 bits.
  - If sum_x>=SCREEN_W or sum_y>=SCREEN_H, writeEn=0 for that cycle; the cycle is still consumed.
  - x_out/y_out carry the truncated sum.
- CLEAR: sweeps x 0..SCREEN_W-1, y 0..SCREEN_H-1 with colour_out=0 and writeEn=1, SCREEN_W*SCREEN_H cycles. x_base, y_base and colour are unchanged.
- After the last DRAW or CLEAR pixel: DONE for one cycle, with done=1, writeEn=0, busy=0. Then IDLE.
- writeEn is never high outside DRAW/CLEAR.
- Reset mid-operation: abort; writeEn=0 from the next cycle; no done pulse.
- ld_x and plot both high in IDLE: plot wins; x_base is not updated.

Decomposition:
- Package vga_draw_pkg:
  - State enum.
  - Localparams: CLR_COLOUR=0, DX_W=$clog2(BOX_W), DY_W=$clog2(BOX_H), SX_W=$clog2(SCREEN_W), SY_W=$clog2(SCREEN_H). Each counter width is at least 1.
- Sub-module xy_scan_counter, parametrised (LIM_X, LIM_Y):
  - Inputs: clear, enable.
  - Outputs: cx, cy, last (high on the final count).
  - Instantiated twice: box sweep and screen sweep.

Test Plan:
- ld_x with data_in=10, then plot with data_in=20, colour_in=3'b101 -> 16 writeEn cycles, (10,20)..(13,23) in raster order, colour 5, then one done pulse; busy high for exactly 16 cycles.
- x_base=158, y_base=118 -> 16 DRAW cycles; writeEn high only for (158..159, 118..119), i.e. 4 pixels.
- black -> 19200 writeEn cycles, colour 0, last pixel (159,119), then done; plot/ld_x pulses during the clear are ignored.
- Assert ResetN=0 during DRAW pixel 5 -> next cycle writeEn=0, busy=0, no done pulse; a following plot with no ld_x draws at x_base=0.
- ld_x, plot and black all high in IDLE -> CLEAR starts and x_base is unchanged; plot and ld_x together -> draw uses the old x_base.
- Parameter sweep BOX_W=1, BOX_H=1, SCREEN_W=8, SCREEN_H=4 -> single-pixel plot gives one writeEn cycle; clear gives 32.

Source files
------------

// File: rtl/vga_draw_pkg.sv
// Shared types and constants for the VGA draw controller.
package vga_draw_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_XHELD,
    S_DRAW,
    S_CLEAR,
    S_DONE
  } state_e;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CLR_COLOUR = 0;

  // Widths for the stock 4x4 box on a 160x120 screen; the top derives its
  // own widths from its parameters with cnt_w().
  localparam int DX_W = cnt_w(4);
  localparam int DY_W = cnt_w(4);
  localparam int SX_W = cnt_w(160);
  localparam int SY_W = cnt_w(120);

endpackage

// File: rtl/xy_scan_counter.sv
// Raster-order 2-D counter: cx runs 0..LIM_X-1 fastest, then cy steps.
module xy_scan_counter
  import vga_draw_pkg::*;
#(
  parameter int LIM_X = 4,
  parameter int LIM_Y = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clear_i,
  input  logic                       enable_i,
  output logic [cnt_w(LIM_X)-1:0]    cx_o,
  output logic [cnt_w(LIM_Y)-1:0]    cy_o,
  output logic                       last_o
);

  localparam int CXW = cnt_w(LIM_X);
  localparam int CYW = cnt_w(LIM_Y);

  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic           x_end, y_end;

  assign x_end  = (cx_q == CXW'(LIM_X - 1));
  assign y_end  = (cy_q == CYW'(LIM_Y - 1));
  assign last_o = x_end && y_end;
  assign cx_o   = cx_q;
  assign cy_o   = cy_q;

  // Next position: wrap x into the next row, wrap the whole sweep at the end.
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (enable_i) begin
      if (x_end) begin
        cx_d = '0;
        cy_d = y_end ? '0 : cy_q + CYW'(1);
      end else begin
        cx_d = cx_q + CXW'(1);
      end
    end
  end

  // Position register; clear has priority over counting.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/vga_draw_controller.sv
// VGA plotting control: latch X, then Y/colour, sweep a clipped box into the
// adapter one pixel per clock; also a full-screen clear to black.
module vga_draw_controller
  import vga_draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int BOX_W    = 4,
  parameter int BOX_H    = 4
) (
  input  logic                clock,
  input  logic                ResetN,
  input  logic [X_W-1:0]      data_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                ld_x,
  input  logic                plot,
  input  logic                black,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                writeEn,
  output logic                busy,
  output logic                done
);

  localparam int BXW = cnt_w(BOX_W);
  localparam int BYW = cnt_w(BOX_H);
  localparam int SXW = cnt_w(SCREEN_W);
  localparam int SYW = cnt_w(SCREEN_H);

  state_e              state_q;
  logic [X_W-1:0]      x_base_q;
  logic [Y_W-1:0]      y_base_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] col_q;
  logic                we_q, busy_q, done_q;
  // Set when the pixel currently on the outputs is the final one of the sweep.
  logic                last_q;

  logic [BXW-1:0] box_cx;
  logic [BYW-1:0] box_cy;
  logic [SXW-1:0] scr_cx;
  logic [SYW-1:0] scr_cy;
  logic           box_last, scr_last;

  logic idle_like, start_draw, start_clear, box_en, scr_en;
  logic [Y_W-1:0]      y_src_d;
  logic [COLOUR_W-1:0] col_src_d;
  logic [X_W:0]        sum_x_d;
  logic [Y_W:0]        sum_y_d;
  logic                box_in_d;

  assign idle_like   = (state_q == S_IDLE) || (state_q == S_XHELD);
  assign start_clear = idle_like && black;
  assign start_draw  = idle_like && !black && plot;

  // Counters always point at the pixel to be emitted at the next edge, so
  // they step on the start edge too; outside a sweep they sit at zero.
  assign box_en = start_draw  || ((state_q == S_DRAW)  && !last_q);
  assign scr_en = start_clear || ((state_q == S_CLEAR) && !last_q);

  xy_scan_counter #(.LIM_X(BOX_W), .LIM_Y(BOX_H)) u_box_cnt (
    .clk_i    (clock),
    .rst_n_i  (ResetN),
    .clear_i  (!box_en),
    .enable_i (box_en),
    .cx_o     (box_cx),
    .cy_o     (box_cy),
    .last_o   (box_last)
  );

  xy_scan_counter #(.LIM_X(SCREEN_W), .LIM_Y(SCREEN_H)) u_scr_cnt (
    .clk_i    (clock),
    .rst_n_i  (ResetN),
    .clear_i  (!scr_en),
    .enable_i (scr_en),
    .cx_o     (scr_cx),
    .cy_o     (scr_cy),
    .last_o   (scr_last)
  );

  // Box pixel position and clip test; on the start edge Y and colour come
  // straight from the inputs since their registers load on that same edge.
  always_comb begin
    y_src_d   = start_draw ? data_in[Y_W-1:0] : y_base_q;
    col_src_d = start_draw ? colour_in : colour_q;
    sum_x_d   = {1'b0, x_base_q} + (X_W+1)'(box_cx);
    sum_y_d   = {1'b0, y_src_d}  + (Y_W+1)'(box_cy);
    box_in_d  = (sum_x_d < (X_W+1)'(SCREEN_W)) && (sum_y_d < (Y_W+1)'(SCREEN_H));
  end

  // Control FSM with registered pixel, strobe and handshake outputs.
  always_ff @(posedge clock) begin
    if (!ResetN) begin
      state_q  <= S_IDLE;
      x_base_q <= '0;
      y_base_q <= '0;
      colour_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_XHELD: begin
          if (black) begin
            state_q <= S_CLEAR;
            x_q     <= X_W'(scr_cx);
            y_q     <= Y_W'(scr_cy);
            col_q   <= COLOUR_W'(CLR_COLOUR);
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
            last_q  <= scr_last;
          end else if (plot) begin
            state_q  <= S_DRAW;
            y_base_q <= data_in[Y_W-1:0];
            colour_q <= colour_in;
            x_q      <= sum_x_d[X_W-1:0];
            y_q      <= sum_y_d[Y_W-1:0];
            col_q    <= col_src_d;
            we_q     <= box_in_d;
            busy_q   <= 1'b1;
            last_q   <= box_last;
          end else if (ld_x) begin
            state_q  <= S_XHELD;
            x_base_q <= data_in;
          end
        end
        S_DRAW: begin
          if (last_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            x_q    <= sum_x_d[X_W-1:0];
            y_q    <= sum_y_d[Y_W-1:0];
            col_q  <= col_src_d;
            we_q   <= box_in_d;
            busy_q <= 1'b1;
            last_q <= box_last;
          end
        end
        S_CLEAR: begin
          if (last_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            x_q    <= X_W'(scr_cx);
            y_q    <= Y_W'(scr_cy);
            col_q  <= COLOUR_W'(CLR_COLOUR);
            we_q   <= 1'b1;
            busy_q <= 1'b1;
            last_q <= scr_last;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = col_q;
  assign writeEn    = we_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_vga_draw_controller.sv
// Bench for vga_draw_controller: a stock 160x120/4x4 instance and a tiny
// 8x4/1x1 instance share the stimulus; each has its own cycle-level model.
module tb_vga_draw_controller;

  logic       clock = 1'b0;
  logic       ResetN = 1'b0;
  logic [7:0] data_in = '0;
  logic [2:0] colour_in = '0;
  logic       ld_x = 1'b0, plot = 1'b0, black = 1'b0;

  logic [7:0] xo [2];
  logic [6:0] yo [2];
  logic [2:0] co [2];
  logic       we [2], bz [2], dn [2];

  always #5 clock = ~clock;

  vga_draw_controller #(.X_W(8), .Y_W(7), .COLOUR_W(3), .SCREEN_W(160), .SCREEN_H(120),
                        .BOX_W(4), .BOX_H(4)) dut0 (
    .clock(clock), .ResetN(ResetN), .data_in(data_in), .colour_in(colour_in),
    .ld_x(ld_x), .plot(plot), .black(black), .x_out(xo[0]), .y_out(yo[0]),
    .colour_out(co[0]), .writeEn(we[0]), .busy(bz[0]), .done(dn[0]));

  vga_draw_controller #(.X_W(8), .Y_W(7), .COLOUR_W(3), .SCREEN_W(8), .SCREEN_H(4),
                        .BOX_W(1), .BOX_H(1)) dut1 (
    .clock(clock), .ResetN(ResetN), .data_in(data_in), .colour_in(colour_in),
    .ld_x(ld_x), .plot(plot), .black(black), .x_out(xo[1]), .y_out(yo[1]),
    .colour_out(co[1]), .writeEn(we[1]), .busy(bz[1]), .done(dn[1]));

  // ---------------- model ----------------
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       we, bz, dn, chk;
  } exp_t;

  int   SWv [2] = '{160, 8};
  int   SHv [2] = '{120, 4};
  int   BWv [2] = '{4, 1};
  int   BHv [2] = '{4, 1};
  int   xb [2], yb [2], cb [2];
  int   sx, sy;
  exp_t e [2];
  exp_t q [2][$];

  function automatic exp_t mk(input int x, input int y, input int c,
                              input bit w, input bit b, input bit d, input bit k);
    exp_t r;
    r.x = 8'(x); r.y = 7'(y); r.c = 3'(c);
    r.we = w; r.bz = b; r.dn = d; r.chk = k;
    return r;
  endfunction

  // Each operation is expanded into its whole list of per-cycle outputs:
  // the pixels, one done cycle, then one idle cycle whose inputs are ignored.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!ResetN) begin
        q[i].delete();
        e[i]  = mk(0, 0, 0, 0, 0, 0, 1);
        xb[i] = 0; yb[i] = 0; cb[i] = 0;
      end else if (q[i].size() != 0) begin
        e[i] = q[i].pop_front();
      end else if (black) begin
        for (int y = 0; y < SHv[i]; y++)
          for (int x = 0; x < SWv[i]; x++)
            q[i].push_back(mk(x, y, 0, 1, 1, 0, 1));
        q[i].push_back(mk(0, 0, 0, 0, 0, 1, 0));
        q[i].push_back(mk(0, 0, 0, 0, 0, 0, 0));
        e[i] = q[i].pop_front();
      end else if (plot) begin
        yb[i] = int'(data_in[6:0]);
        cb[i] = int'(colour_in);
        for (int dy = 0; dy < BHv[i]; dy++)
          for (int dx = 0; dx < BWv[i]; dx++) begin
            sx = xb[i] + dx;
            sy = yb[i] + dy;
            q[i].push_back(mk(sx, sy, cb[i], (sx < SWv[i]) && (sy < SHv[i]), 1, 0, 1));
          end
        q[i].push_back(mk(0, 0, 0, 0, 0, 1, 0));
        q[i].push_back(mk(0, 0, 0, 0, 0, 0, 0));
        e[i] = q[i].pop_front();
      end else begin
        if (ld_x) xb[i] = int'(data_in);
        e[i] = mk(0, 0, 0, 0, 0, 0, 0);
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0, bad = 0;
  bit go = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic chkc(input int i, input string f, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL dut%0d %s: got %0d, want %0d (t=%0t)", i, f, act, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    if (go) begin
      for (int i = 0; i < 2; i++) begin
        chkc(i, "writeEn", int'(we[i]), int'(e[i].we));
        chkc(i, "busy",    int'(bz[i]), int'(e[i].bz));
        chkc(i, "done",    int'(dn[i]), int'(e[i].dn));
        if (e[i].chk) begin
          chkc(i, "x_out",      int'(xo[i]), int'(e[i].x));
          chkc(i, "y_out",      int'(yo[i]), int'(e[i].y));
          chkc(i, "colour_out", int'(co[i]), int'(e[i].c));
        end
      end
    end
  end

  // Per-operation statistics for the hand-computed expectations.
  int wc [2], bc [2], dc [2], fx [2], fy [2], lx [2], ly [2], lc [2];

  always @(negedge clock) begin
    if (go) begin
      for (int i = 0; i < 2; i++) begin
        if (we[i]) begin
          if (wc[i] == 0) begin fx[i] = int'(xo[i]); fy[i] = int'(yo[i]); end
          lx[i] = int'(xo[i]); ly[i] = int'(yo[i]); lc[i] = int'(co[i]);
          wc[i]++;
        end
        if (bz[i]) bc[i]++;
        if (dn[i]) dc[i]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic clr_stats();
    for (int i = 0; i < 2; i++) begin
      wc[i] = 0; bc[i] = 0; dc[i] = 0;
      fx[i] = -1; fy[i] = -1; lx[i] = -1; ly[i] = -1; lc[i] = -1;
    end
  endtask

  task automatic op(input bit l, input bit p, input bit b, input int d, input int c);
    ld_x = l; plot = p; black = b;
    data_in = 8'(d); colour_in = 3'(c);
    cyc();
    ld_x = 1'b0; plot = 1'b0; black = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    int n;
    n = 0;
    while (!dn[0] && n < maxc) begin cyc(); n++; end
    chk(nm, int'(dn[0]), 1);
    cyc();
  endtask

  initial begin
    clr_stats();
    cyc();
    go = 1'b1;
    cyc();
    chk("reset writeEn", int'(we[0]), 0);
    chk("reset busy",    int'(bz[0]), 0);
    chk("reset done",    int'(dn[0]), 0);
    chk("reset x_out",   int'(xo[0]), 0);
    ResetN = 1'b1;
    cyc();

    // basic box at (10,20), colour 5
    clr_stats();
    op(1, 0, 0, 10, 0);
    op(0, 1, 0, 20, 5);
    wait_done(100, "t1 done seen");
    chk("t1 writes", wc[0], 16);
    chk("t1 busy cycles", bc[0], 16);
    chk("t1 done pulses", dc[0], 1);
    chk("t1 first x", fx[0], 10);
    chk("t1 first y", fy[0], 20);
    chk("t1 last x", lx[0], 13);
    chk("t1 last y", ly[0], 23);
    chk("t1 colour", lc[0], 5);
    chk("t1 small writes", wc[1], 0);
    chk("t1 small busy", bc[1], 1);

    // bottom-right corner clipping
    clr_stats();
    op(1, 0, 0, 158, 0);
    op(0, 1, 0, 118, 2);
    wait_done(100, "t2 done seen");
    chk("t2 writes", wc[0], 4);
    chk("t2 busy cycles", bc[0], 16);
    chk("t2 first x", fx[0], 158);
    chk("t2 first y", fy[0], 118);
    chk("t2 last x", lx[0], 159);
    chk("t2 last y", ly[0], 119);

    // coordinate sums that overflow the output width
    clr_stats();
    op(1, 0, 0, 254, 0);
    op(0, 1, 0, 126, 6);
    wait_done(100, "t2b done seen");
    chk("t2b writes", wc[0], 0);
    chk("t2b busy cycles", bc[0], 16);

    // single pixel on the small instance
    clr_stats();
    op(1, 0, 0, 3, 0);
    op(0, 1, 0, 2, 7);
    wait_done(100, "t3 done seen");
    chk("t3 small writes", wc[1], 1);
    chk("t3 small x", fx[1], 3);
    chk("t3 small y", fy[1], 2);
    chk("t3 small colour", lc[1], 7);
    chk("t3 writes", wc[0], 16);

    // full clear with ignored plot/ld_x pulses
    clr_stats();
    op(0, 0, 1, 0, 0);
    repeat (3) cyc();
    op(0, 1, 0, 50, 4);
    repeat (3) cyc();
    op(1, 0, 0, 99, 0);
    wait_done(20000, "t4 done seen");
    chk("t4 writes", wc[0], 19200);
    chk("t4 busy cycles", bc[0], 19200);
    chk("t4 done pulses", dc[0], 1);
    chk("t4 last x", lx[0], 159);
    chk("t4 last y", ly[0], 119);
    chk("t4 last colour", lc[0], 0);
    chk("t4 small writes", wc[1], 32);
    chk("t4 small done", dc[1], 1);

    // reset during the fifth pixel; x_base survives the clear, then resets
    clr_stats();
    op(0, 1, 0, 5, 1);
    chk("t5 x after clear", int'(xo[0]), 3);
    repeat (4) cyc();
    ResetN = 1'b0;
    cyc();
    chk("t5 writeEn after reset", int'(we[0]), 0);
    chk("t5 busy after reset", int'(bz[0]), 0);
    ResetN = 1'b1;
    clr_stats();
    repeat (6) cyc();
    chk("t5 no done", dc[0], 0);
    chk("t5 small no done", dc[1], 0);
    clr_stats();
    op(0, 1, 0, 7, 1);
    wait_done(100, "t5 done seen");
    chk("t5 first x", fx[0], 0);
    chk("t5 first y", fy[0], 7);
    chk("t5 writes", wc[0], 16);

    // priority: black beats plot and ld_x; plot beats ld_x
    clr_stats();
    op(1, 1, 1, 99, 6);
    chk("t6 clear busy", int'(bz[0]), 1);
    chk("t6 clear colour", int'(co[0]), 0);
    wait_done(20000, "t6 clear done seen");
    chk("t6 clear writes", wc[0], 19200);
    clr_stats();
    op(1, 1, 0, 50, 3);
    chk("t6 draw x", int'(xo[0]), 0);
    chk("t6 draw y", int'(yo[0]), 50);
    wait_done(100, "t6 draw done seen");
    chk("t6 first x", fx[0], 0);
    chk("t6 colour", lc[0], 3);
    chk("t6 writes", wc[0], 16);

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
